// File: rtl/wb_axi4_ddr_bridge.sv
// -----------------------------------------------------------------------------
// wb_axi4_ddr_bridge
//
// Purpose
//   Wishbone B3 classic slave to AXI4 master bridge for the board's DDR AXI
//   slave port. The bridge runs in the sys_clk/sys_rst domain (MIG UI clock).
//   It handles one single-beat transaction at a time, so the SoC Wishbone
//   interconnect can reach DDR2 without a full AXI crossbar.
//
// Optional feature (compile-time macro)
//   WB_AXI_TIMEOUT_EN : enables the response timeout counter and drain logic.
//                       If it is not defined, the bridge waits indefinitely.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   wb_adr_i/dat_i/sel_i/we_i Wishbone request (byte address, write data, selects)
//   wb_cyc_i, wb_stb_i        Wishbone cycle / strobe
//   wb_dat_o                  read data (holds the last captured rdata)
//   wb_ack_o, wb_err_o        one-cycle termination pulses, mutually exclusive
//   ddr_aw* / ddr_w* / ddr_b* AXI4 write address, data and response channels
//   ddr_ar* / ddr_r*          AXI4 read address and data channels
//   dbg_state_o               current FSM state, for observation
//
// Handshake rule: a channel transfers on a clock edge where valid and ready are
// both high. A valid raised by the bridge stays high with a stable payload
// until that edge. The bridge raises a ready only in the state that expects the
// beat.
// -----------------------------------------------------------------------------
module wb_axi4_ddr_bridge #(
    parameter int ADDR_WIDTH     = 28,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 4,
    parameter int AXI_ID         = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    // Wishbone slave
    input  logic [31:0]             wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    // AXI write address
    output logic [ID_WIDTH-1:0]     ddr_awid,
    output logic [ADDR_WIDTH-1:0]   ddr_awaddr,
    output logic [7:0]              ddr_awlen,
    output logic [2:0]              ddr_awsize,
    output logic [1:0]              ddr_awburst,
    output logic [3:0]              ddr_awcache,
    output logic [2:0]              ddr_awprot,
    output logic [3:0]              ddr_awqos,
    output logic                    ddr_awvalid,
    input  logic                    ddr_awready,
    // AXI write data
    output logic [DATA_WIDTH-1:0]   ddr_wdata,
    output logic [DATA_WIDTH/8-1:0] ddr_wstrb,
    output logic                    ddr_wlast,
    output logic                    ddr_wvalid,
    input  logic                    ddr_wready,
    // AXI write response
    input  logic [ID_WIDTH-1:0]     ddr_bid,
    input  logic [1:0]              ddr_bresp,
    input  logic                    ddr_bvalid,
    output logic                    ddr_bready,
    // AXI read address
    output logic [ID_WIDTH-1:0]     ddr_arid,
    output logic [ADDR_WIDTH-1:0]   ddr_araddr,
    output logic [7:0]              ddr_arlen,
    output logic [2:0]              ddr_arsize,
    output logic [1:0]              ddr_arburst,
    output logic [3:0]              ddr_arcache,
    output logic [2:0]              ddr_arprot,
    output logic [3:0]              ddr_arqos,
    output logic                    ddr_arvalid,
    input  logic                    ddr_arready,
    // AXI read data
    input  logic [DATA_WIDTH-1:0]   ddr_rdata,
    input  logic                    ddr_rlast,
    input  logic [ID_WIDTH-1:0]     ddr_rid,
    input  logic [1:0]              ddr_rresp,
    input  logic                    ddr_rvalid,
    output logic                    ddr_rready,
    // Observation
    output logic [2:0]              dbg_state_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [2:0] AX_SIZE = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       strb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                    aw_done_q, w_done_q;
    logic                    ack_q, err_q;
    logic                    resp_err_q;
    // Set when the master drops wb_cyc_i mid-transaction: the AXI side still
    // completes, but no termination is returned for the abandoned cycle.
    logic                    abort_q;

    // An AXI channel counts as finished if it handshook earlier or does so now.
    logic aw_fin, w_fin;
    assign aw_fin = aw_done_q | (awvalid_q & ddr_awready);
    assign w_fin  = w_done_q  | (wvalid_q  & ddr_wready);

    logic wb_req;
    assign wb_req = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;

`ifdef WB_AXI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             drain_q;
    logic             busy, step_done, addr_accepted;

    assign busy = (state_q == S_WR_ADDR) || (state_q == S_WR_RESP) ||
                  (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
    // The state is left on this edge, so the timeout must not fire.
    assign step_done = ((state_q == S_WR_ADDR) && aw_fin && w_fin) ||
                       ((state_q == S_WR_RESP) && ddr_bvalid) ||
                       ((state_q == S_RD_ADDR) && ddr_arready) ||
                       ((state_q == S_RD_DATA) && ddr_rvalid);
    // A late response can arrive only if the slave accepted the address.
    assign addr_accepted = ((state_q == S_WR_ADDR) && aw_fin) ||
                           (state_q == S_WR_RESP) || (state_q == S_RD_DATA);
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            resp_err_q <= 1'b0;
            abort_q    <= 1'b0;
`ifdef WB_AXI_TIMEOUT_EN
            cnt_q      <= '0;
            drain_q    <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if ((state_q != S_IDLE) && !wb_cyc_i) begin
                abort_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
`ifdef WB_AXI_TIMEOUT_EN
                    if (drain_q) begin
                        if ((bready_q && ddr_bvalid) || (rready_q && ddr_rvalid)) begin
                            drain_q  <= 1'b0;
                            bready_q <= 1'b0;
                            rready_q <= 1'b0;
                        end
                    end else
`endif
                    if (wb_req) begin
                        addr_q     <= {wb_adr_i[ADDR_WIDTH-1:2], 2'b00};
                        wdata_q    <= wb_dat_i;
                        strb_q     <= wb_sel_i;
                        abort_q    <= 1'b0;
                        resp_err_q <= 1'b0;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        if (wb_we_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_ADDR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_ADDR;
                        end
                    end
                end

                S_WR_ADDR: begin
                    if (awvalid_q && ddr_awready) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && ddr_wready) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end

                S_WR_RESP: begin
                    if (ddr_bvalid) begin
                        bready_q   <= 1'b0;
                        resp_err_q <= (ddr_bresp != 2'b00);
                        state_q    <= S_DONE;
                    end
                end

                S_RD_ADDR: begin
                    if (ddr_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (ddr_rvalid) begin
                        rready_q   <= 1'b0;
                        rdata_q    <= ddr_rdata;
                        resp_err_q <= (ddr_rresp != 2'b00);
                        state_q    <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (wb_cyc_i && !abort_q) begin
                        ack_q <= ~resp_err_q;
                        err_q <= resp_err_q;
                    end
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase

`ifdef WB_AXI_TIMEOUT_EN
            // Placed after the case so that the timeout overrides its assignments.
            if (busy) begin
                if (step_done) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_q     <= '0;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    arvalid_q <= 1'b0;
                    bready_q  <= addr_accepted;
                    rready_q  <= addr_accepted;
                    drain_q   <= addr_accepted;
                    err_q     <= wb_cyc_i & ~abort_q;
                    state_q   <= S_IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
`endif
        end
    end

    // Outputs
    assign wb_dat_o    = rdata_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign dbg_state_o = state_q;

    assign ddr_awid    = ID_WIDTH'(AXI_ID);
    assign ddr_awaddr  = addr_q;
    assign ddr_awlen   = 8'd0;
    assign ddr_awsize  = AX_SIZE;
    assign ddr_awburst = 2'b01;
    assign ddr_awcache = 4'b0011;
    assign ddr_awprot  = 3'b000;
    assign ddr_awqos   = 4'b0000;
    assign ddr_awvalid = awvalid_q;

    assign ddr_wdata   = wdata_q;
    assign ddr_wstrb   = strb_q;
    assign ddr_wlast   = 1'b1;
    assign ddr_wvalid  = wvalid_q;
    assign ddr_bready  = bready_q;

    assign ddr_arid    = ID_WIDTH'(AXI_ID);
    assign ddr_araddr  = addr_q;
    assign ddr_arlen   = 8'd0;
    assign ddr_arsize  = AX_SIZE;
    assign ddr_arburst = 2'b01;
    assign ddr_arcache = 4'b0011;
    assign ddr_arprot  = 3'b000;
    assign ddr_arqos   = 4'b0000;
    assign ddr_arvalid = arvalid_q;
    assign ddr_rready  = rready_q;

    // The IDs and rlast need no check because only one single-beat transaction
    // is outstanding. The upper address bits lie outside the DDR window.
    logic unused_inputs;
    assign unused_inputs = ^{ddr_bid, ddr_rid, ddr_rlast, wb_adr_i};

endmodule

// File: tb/tb_wb_axi4_ddr_bridge.sv
module tb_wb_axi4_ddr_bridge;

    localparam int AW = 28;
    localparam int DW = 32;
    localparam int IW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [31:0]   wb_adr_i;
    logic [DW-1:0] wb_dat_i, wb_dat_o;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
    logic [IW-1:0] ddr_awid, ddr_arid, ddr_bid, ddr_rid;
    logic [AW-1:0] ddr_awaddr, ddr_araddr;
    logic [7:0]    ddr_awlen, ddr_arlen;
    logic [2:0]    ddr_awsize, ddr_arsize, ddr_awprot, ddr_arprot;
    logic [1:0]    ddr_awburst, ddr_arburst, ddr_bresp, ddr_rresp;
    logic [3:0]    ddr_awcache, ddr_arcache, ddr_awqos, ddr_arqos;
    logic          ddr_awvalid, ddr_awready, ddr_wlast, ddr_wvalid, ddr_wready;
    logic [DW-1:0] ddr_wdata, ddr_rdata;
    logic [3:0]    ddr_wstrb;
    logic          ddr_bvalid, ddr_bready, ddr_arvalid, ddr_arready;
    logic          ddr_rlast, ddr_rvalid, ddr_rready;
    logic [2:0]    dbg_state_o;

    wb_axi4_ddr_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(0), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .ddr_awid(ddr_awid), .ddr_awaddr(ddr_awaddr), .ddr_awlen(ddr_awlen),
        .ddr_awsize(ddr_awsize), .ddr_awburst(ddr_awburst), .ddr_awcache(ddr_awcache),
        .ddr_awprot(ddr_awprot), .ddr_awqos(ddr_awqos), .ddr_awvalid(ddr_awvalid),
        .ddr_awready(ddr_awready),
        .ddr_wdata(ddr_wdata), .ddr_wstrb(ddr_wstrb), .ddr_wlast(ddr_wlast),
        .ddr_wvalid(ddr_wvalid), .ddr_wready(ddr_wready),
        .ddr_bid(ddr_bid), .ddr_bresp(ddr_bresp), .ddr_bvalid(ddr_bvalid), .ddr_bready(ddr_bready),
        .ddr_arid(ddr_arid), .ddr_araddr(ddr_araddr), .ddr_arlen(ddr_arlen),
        .ddr_arsize(ddr_arsize), .ddr_arburst(ddr_arburst), .ddr_arcache(ddr_arcache),
        .ddr_arprot(ddr_arprot), .ddr_arqos(ddr_arqos), .ddr_arvalid(ddr_arvalid),
        .ddr_arready(ddr_arready),
        .ddr_rdata(ddr_rdata), .ddr_rlast(ddr_rlast), .ddr_rid(ddr_rid), .ddr_rresp(ddr_rresp),
        .ddr_rvalid(ddr_rvalid), .ddr_rready(ddr_rready),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pops the expected read data and compares it with the captured wb_dat_o.
    task automatic check_rdata(input string tag, input logic [DW-1:0] got);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(got), 64'(e));
        end
    endtask

    // ---------------- results of one transfer ----------------
    int            r_lat, r_ack, r_err, r_aw_hs, r_w_hs, r_b_hs, r_ar_hs, r_r_hs;
    int            r_aw_c, r_w_c;
    logic          r_fin;
    logic [AW-1:0] r_awaddr, r_araddr;
    logic [DW-1:0] r_wdata, r_dat;
    logic [3:0]    r_wstrb;

    task automatic idle_inputs();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        ddr_awready = 1'b0; ddr_wready = 1'b0; ddr_arready = 1'b0;
        ddr_bvalid = 1'b0; ddr_bresp = 2'b00; ddr_bid = '0;
        ddr_rvalid = 1'b0; ddr_rresp = 2'b00; ddr_rid = '0; ddr_rdata = '0; ddr_rlast = 1'b0;
    endtask

    // One Wishbone cycle plus an AXI slave model with per-channel delays.
    // Everything happens on the falling edge. The handshakes of the previous
    // rising edge are resolved first, then the outputs are observed, and then
    // new inputs are driven. c = 0 is the falling edge on which stb is raised.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [DW-1:0] dat,
                           input logic [3:0] sel, input int aw_dly, input int w_dly,
                           input int rsp_dly, input logic [1:0] resp,
                           input logic [DW-1:0] rdata, input int abort_c);
        int aw_wait, w_wait, ar_wait, rsp_wait, fin_c;
        logic p_aw, p_w, p_b, p_ar, p_r, seen;
        aw_wait = 0; w_wait = 0; ar_wait = 0; rsp_wait = 0; fin_c = 0;
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0; seen = 0;
        r_lat = -1; r_ack = 0; r_err = 0; r_aw_hs = 0; r_w_hs = 0; r_b_hs = 0;
        r_ar_hs = 0; r_r_hs = 0; r_aw_c = 0; r_w_c = 0; r_fin = 1'b0;
        r_awaddr = '0; r_araddr = '0; r_wdata = '0; r_wstrb = '0; r_dat = '0;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        for (int c = 0; c < 60; c++) begin
            if (c != 0) @(negedge clk);
            if (p_aw) begin r_aw_hs++; r_aw_c = c; end
            if (p_w)  begin r_w_hs++;  r_w_c  = c; end
            if (p_ar) r_ar_hs++;
            if (p_b)  begin r_b_hs++; ddr_bvalid = 1'b0; fin_c = c; end
            if (p_r)  begin r_r_hs++; ddr_rvalid = 1'b0; ddr_rlast = 1'b0; fin_c = c; end
            if (wb_ack_o) begin
                r_ack++;
                if (!seen) begin seen = 1; r_lat = c; r_dat = wb_dat_o; end
            end
            if (wb_err_o) begin
                r_err++;
                if (!seen) begin seen = 1; r_lat = c; end
            end
            if (seen || (abort_c > 0 && c >= abort_c)) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
            ddr_awready = 1'b0;
            if (ddr_awvalid) begin ddr_awready = (aw_wait >= aw_dly); aw_wait++; end
            ddr_wready = 1'b0;
            if (ddr_wvalid) begin ddr_wready = (w_wait >= w_dly); w_wait++; end
            ddr_arready = 1'b0;
            if (ddr_arvalid) begin ddr_arready = (ar_wait >= 0); ar_wait++; end
            if (we && r_aw_hs > 0 && r_w_hs > 0 && r_b_hs == 0 && !ddr_bvalid) begin
                if (rsp_wait >= rsp_dly) begin ddr_bvalid = 1'b1; ddr_bresp = resp; end
                else rsp_wait++;
            end
            if (!we && r_ar_hs > 0 && r_r_hs == 0 && !ddr_rvalid) begin
                if (rsp_wait >= rsp_dly) begin
                    ddr_rvalid = 1'b1; ddr_rdata = rdata; ddr_rresp = resp; ddr_rlast = 1'b1;
                end else rsp_wait++;
            end
            p_aw = ddr_awvalid && ddr_awready;
            p_w  = ddr_wvalid && ddr_wready;
            p_ar = ddr_arvalid && ddr_arready;
            p_b  = ddr_bvalid && ddr_bready;
            p_r  = ddr_rvalid && ddr_rready;
            if (p_aw) r_awaddr = ddr_awaddr;
            if (p_w)  begin r_wdata = ddr_wdata; r_wstrb = ddr_wstrb; end
            if (p_ar) r_araddr = ddr_araddr;
            if (((we && r_b_hs > 0) || (!we && r_r_hs > 0)) && c >= fin_c + 3) begin
                r_fin = 1'b1;
                break;
            end
        end
        check("xfer_completed", 64'(r_fin), 64'd1);
        idle_inputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Outputs during reset and the constant AXI attributes
        check("rst_valids_readies",
              64'({ddr_awvalid, ddr_wvalid, ddr_bready, ddr_arvalid, ddr_rready}), 64'd0);
        check("rst_ack_err", 64'({wb_ack_o, wb_err_o}), 64'd0);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        check("rst_state", 64'(dbg_state_o), 64'd0);
        check("const_aw", 64'({ddr_awid, ddr_awlen, ddr_awsize, ddr_awburst, ddr_awcache,
                               ddr_awprot, ddr_awqos, ddr_wlast}),
              64'({4'h0, 8'h00, 3'b010, 2'b01, 4'b0011, 3'b000, 4'b0000, 1'b1}));
        check("const_ar", 64'({ddr_arid, ddr_arlen, ddr_arsize, ddr_arburst, ddr_arcache,
                               ddr_arprot, ddr_arqos}),
              64'({4'h0, 8'h00, 3'b010, 2'b01, 4'b0011, 3'b000, 4'b0000}));
        rst = 1'b0;
        @(negedge clk);

        // 1: basic write to a ready slave
        wb_xfer(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, '0, 0);
        check("t1_awaddr", 64'(r_awaddr), 64'h100);
        check("t1_wdata", 64'(r_wdata), 64'hDEAD_BEEF);
        check("t1_wstrb", 64'(r_wstrb), 64'hF);
        check("t1_ack_err", 64'({r_ack[3:0], r_err[3:0]}), 64'h10);
        check("t1_latency", 64'(r_lat), 64'd4);
        check("t1_b_count", 64'(r_b_hs), 64'd1);

        // 2: awready delayed 3 cycles, wready immediate
        wb_xfer(1'b1, 32'h0000_0207, 32'hA5A5_0F0F, 4'h3, 3, 0, 0, 2'b00, '0, 0);
        check("t2_w_before_aw", 64'(r_w_c < r_aw_c), 64'd1);
        check("t2_awaddr_aligned", 64'(r_awaddr), 64'h204);
        check("t2_wstrb", 64'(r_wstrb), 64'h3);
        check("t2_b_count", 64'(r_b_hs), 64'd1);
        check("t2_ack", 64'(r_ack), 64'd1);
        check("t2_latency", 64'(r_lat), 64'd7);

        // 2b: wready delayed 2 cycles, awready immediate
        wb_xfer(1'b1, 32'h0000_0300, 32'h0102_0304, 4'h8, 0, 2, 0, 2'b00, '0, 0);
        check("t2b_aw_before_w", 64'(r_aw_c < r_w_c), 64'd1);
        check("t2b_latency", 64'(r_lat), 64'd6);

        // 3: read at the top of the DDR window, data after 5 cycles
        exp_q.push_back(32'h1234_5678);
        wb_xfer(1'b0, 32'h0FFF_FFFC, '0, 4'hF, 0, 0, 5, 2'b00, 32'h1234_5678, 0);
        check("t3_araddr", 64'(r_araddr), 64'h0FFF_FFFC);
        check("t3_ack_err", 64'({r_ack[3:0], r_err[3:0]}), 64'h10);
        check("t3_latency", 64'(r_lat), 64'd9);
        check_rdata("t3_rdata", r_dat);

        // Upper address bits are dropped and the low two bits are cleared
        exp_q.push_back(32'h0BAD_CAFE);
        wb_xfer(1'b0, 32'hF000_0107, '0, 4'hF, 0, 0, 0, 2'b00, 32'h0BAD_CAFE, 0);
        check("tu_araddr", 64'(r_araddr), 64'h000_0104);
        check("tu_latency", 64'(r_lat), 64'd4);
        check_rdata("tu_rdata", r_dat);

        // 4: read with SLVERR gives exactly one err pulse and no ack
        wb_xfer(1'b0, 32'h0000_0040, '0, 4'hF, 0, 0, 0, 2'b10, 32'h5555_5555, 0);
        check("t4_err", 64'(r_err), 64'd1);
        check("t4_no_ack", 64'(r_ack), 64'd0);

        // Write with DECERR
        wb_xfer(1'b1, 32'h0000_0080, 32'h1111_2222, 4'hF, 0, 0, 0, 2'b11, '0, 0);
        check("tw_err", 64'(r_err), 64'd1);
        check("tw_no_ack", 64'(r_ack), 64'd0);

        // cyc dropped after accept: AXI side completes, no termination
        wb_xfer(1'b1, 32'h0000_0500, 32'h7777_8888, 4'hF, 0, 0, 2, 2'b00, '0, 2);
        check("tab_b_count", 64'(r_b_hs), 64'd1);
        check("tab_no_term", 64'({r_ack[3:0], r_err[3:0]}), 64'h00);

        // 5: reset while in WR_RESP
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h0000_0600; wb_dat_i = 32'hFEED_F00D; wb_sel_i = 4'hF;
        ddr_awready = 1'b1; ddr_wready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_in_wr_resp", 64'({dbg_state_o, ddr_bready}), 64'({3'd2, 1'b1}));
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("t5_rst_outputs",
              64'({ddr_awvalid, ddr_wvalid, ddr_bready, ddr_arvalid, ddr_rready,
                   wb_ack_o, wb_err_o}), 64'd0);
        check("t5_rst_state", 64'(dbg_state_o), 64'd0);
        rst = 1'b0;
        exp_q.push_back(32'hCAFE_F00D);
        wb_xfer(1'b0, 32'h0000_0700, '0, 4'hF, 0, 0, 1, 2'b00, 32'hCAFE_F00D, 0);
        check("t5_read_ack", 64'(r_ack), 64'd1);
        check_rdata("t5_read_data", r_dat);

`ifdef WB_AXI_TIMEOUT_EN
        // 6: bvalid withheld, so the transfer times out; the late b is drained
        wb_xfer(1'b1, 32'h0000_0800, 32'h3333_4444, 4'hF, 0, 0, 20, 2'b00, '0, 0);
        check("t6_err", 64'(r_err), 64'd1);
        check("t6_no_ack", 64'(r_ack), 64'd0);
        check("t6_err_latency", 64'(r_lat), 64'd18);
        check("t6_late_b_drained", 64'(r_b_hs), 64'd1);
        check("t6_idle_after_drain", 64'({dbg_state_o, ddr_bready, ddr_rready}), 64'd0);
        wb_xfer(1'b1, 32'h0000_0900, 32'h5A5A_5A5A, 4'hF, 0, 0, 0, 2'b00, '0, 0);
        check("t6_next_write_ack", 64'(r_ack), 64'd1);
        check("t6_next_write_latency", 64'(r_lat), 64'd4);
`endif

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
